// File: rtl/axil_req_arbiter_if.sv
// AXI4-Lite master-port bundle between the request arbiter and the interconnect.
interface axil_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master among NUM_REQ requesters,
// one outstanding transaction at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for any req_valid; grants round-robin from rr_ptr
// S_WR      | AW and W offered together, each drops on its own handshake
// S_WR_RESP | bready high, waiting for the write response
// S_RD_ADDR | arvalid high, waiting for arready
// S_RD_DATA | rready high, waiting for read data
// S_DONE    | one-cycle req_done pulse to the winner
module axil_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_wstrb,
  output logic [NUM_REQ-1:0]                    req_done,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic [1:0]                            rsp_resp,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id,
  output logic                                  busy,
  axil_req_arbiter_if.master                    m_axil
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ID_W       = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;
  logic            pick_found;
  logic            aw_done, w_done;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic            aw_ok, w_ok;

  assign aw_hs = m_axil.awvalid & m_axil.awready;
  assign w_hs  = m_axil.wvalid  & m_axil.wready;
  assign b_hs  = m_axil.bvalid  & m_axil.bready;
  assign ar_hs = m_axil.arvalid & m_axil.arready;
  assign r_hs  = m_axil.rvalid  & m_axil.rready;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done  | w_hs;

  assign busy          = (state != S_IDLE);
  assign m_axil.awprot = 3'b000;
  assign m_axil.arprot = 3'b000;

  // Round-robin pick: first set req_valid searching upward from rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pick_found) state_nxt = req_write[pick_id] ? S_WR : S_RD_ADDR;
      S_WR:      if (aw_ok && w_ok) state_nxt = S_WR_RESP;
      S_WR_RESP: if (b_hs) state_nxt = S_DONE;
      S_RD_ADDR: if (ar_hs) state_nxt = S_RD_DATA;
      S_RD_DATA: if (r_hs) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Registered AXI outputs, grant bookkeeping and response capture.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr         <= '0;
      grant_id       <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      req_done       <= '0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
      m_axil.awaddr  <= '0;
      m_axil.awvalid <= 1'b0;
      m_axil.wdata   <= '0;
      m_axil.wstrb   <= '0;
      m_axil.wvalid  <= 1'b0;
      m_axil.bready  <= 1'b0;
      m_axil.araddr  <= '0;
      m_axil.arvalid <= 1'b0;
      m_axil.rready  <= 1'b0;
    end else begin
      req_done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            rr_ptr   <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            if (req_write[pick_id]) begin
              m_axil.awaddr  <= req_addr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
              m_axil.wdata   <= req_wdata[pick_id*DATA_WIDTH +: DATA_WIDTH];
              m_axil.wstrb   <= req_wstrb[pick_id*STRB_WIDTH +: STRB_WIDTH];
              m_axil.awvalid <= 1'b1;
              m_axil.wvalid  <= 1'b1;
            end else begin
              m_axil.araddr  <= req_addr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
              m_axil.arvalid <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (aw_hs) begin
            m_axil.awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            m_axil.wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if (aw_ok && w_ok) m_axil.bready <= 1'b1;
        end
        S_WR_RESP: begin
          if (b_hs) begin
            m_axil.bready <= 1'b0;
            rsp_resp      <= m_axil.bresp;
            rsp_rdata     <= '0;
            req_done      <= NUM_REQ'(1) << grant_id;
          end
        end
        S_RD_ADDR: begin
          if (ar_hs) begin
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            m_axil.rready <= 1'b0;
            rsp_rdata     <= m_axil.rdata;
            rsp_resp      <= m_axil.rresp;
            req_done      <= NUM_REQ'(1) << grant_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: table of single transactions against a
// configurable-wait slave, plus contention and mid-transaction reset sequences.
module tb_axil_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]  req_done;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [1:0]    grant_id;
  logic          busy;

  axil_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axil ();

  axil_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .grant_id(grant_id), .busy(busy), .m_axil(m_axil)
  );

  always #5 aclk = ~aclk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Slave wait configuration, set by the main sequence.
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  // Slave model: each ready/valid appears after the configured wait cycles.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axil.awready = 1'b0; m_axil.wready = 1'b0; m_axil.arready = 1'b0;
      m_axil.bvalid = 1'b0; m_axil.rvalid = 1'b0;
      m_axil.bresp = 2'b00; m_axil.rresp = 2'b00; m_axil.rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      m_axil.rdata = s_rdata;
      m_axil.bresp = s_bresp;
      m_axil.rresp = s_rresp;
      if (m_axil.awvalid) begin m_axil.awready = (aw_cnt == aw_wait); aw_cnt++; end
      else begin m_axil.awready = 1'b0; aw_cnt = 0; end
      if (m_axil.wvalid) begin m_axil.wready = (w_cnt == w_wait); w_cnt++; end
      else begin m_axil.wready = 1'b0; w_cnt = 0; end
      if (m_axil.arvalid) begin m_axil.arready = (ar_cnt == ar_wait); ar_cnt++; end
      else begin m_axil.arready = 1'b0; ar_cnt = 0; end
      if (m_axil.bready) begin m_axil.bvalid = (b_cnt == b_wait); b_cnt++; end
      else begin m_axil.bvalid = 1'b0; b_cnt = 0; end
      if (m_axil.rready) begin m_axil.rvalid = (r_cnt == r_wait); r_cnt++; end
      else begin m_axil.rvalid = 1'b0; r_cnt = 0; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req_done"}, req_done, 0);
    check({tag, " rsp_rdata"}, rsp_rdata, 0);
    check({tag, " rsp_resp"}, rsp_resp, 0);
    check({tag, " grant_id"}, grant_id, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " valids"}, {m_axil.awvalid, m_axil.wvalid, m_axil.arvalid}, 0);
    check({tag, " readys"}, {m_axil.bready, m_axil.rready}, 0);
    check({tag, " awaddr"}, m_axil.awaddr, 0);
    check({tag, " wdata"}, m_axil.wdata, 0);
    check({tag, " wstrb"}, m_axil.wstrb, 0);
    check({tag, " araddr"}, m_axil.araddr, 0);
    check({tag, " prot"}, {m_axil.awprot, m_axil.arprot}, 0);
  endtask

  typedef struct {
    bit          wr;
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_w, w_w, ar_w, rsp_w;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;   // cycles from grant to req_done
    int          exp_av;    // awvalid (write) or arvalid (read) cycles
    int          exp_wv;    // wvalid cycles
    int          exp_rdy;   // bready or rready cycles
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    string t;
    int done_c = 0, n_done = 0, aw_c = 0, w_c = 0, ar_c = 0, rdy_c = 0;
    t = $sformatf("v%0d", k);
    aw_wait = v.aw_w; w_wait = v.w_w; ar_wait = v.ar_w;
    b_wait = v.rsp_w; r_wait = v.rsp_w;
    s_bresp = v.s_resp; s_rresp = v.s_resp; s_rdata = v.s_rdata;
    @(negedge aclk);
    req_write[v.id] = v.wr;
    req_addr[v.id*AW +: AW] = v.addr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    req_wstrb[v.id*SW +: SW] = v.strb;
    req_valid[v.id] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        check({t, " busy"}, busy, 1);
        check({t, " grant_id"}, grant_id, v.id);
        if (v.wr) begin
          check({t, " awaddr"}, m_axil.awaddr, v.addr);
          check({t, " wdata"}, m_axil.wdata, v.wdata);
          check({t, " wstrb"}, m_axil.wstrb, v.strb);
        end else begin
          check({t, " araddr"}, m_axil.araddr, v.addr);
        end
        req_addr[v.id*AW +: AW] = ~v.addr;
        req_wdata[v.id*DW +: DW] = ~v.wdata;
        req_wstrb[v.id*SW +: SW] = ~v.strb;
      end
      if (c > 1 && done_c == 0 && v.wr) begin
        check({t, " awaddr held"}, m_axil.awaddr, v.addr);
      end
      aw_c += int'(m_axil.awvalid);
      w_c  += int'(m_axil.wvalid);
      ar_c += int'(m_axil.arvalid);
      rdy_c += int'(m_axil.bready | m_axil.rready);
      if (req_done != 0) begin
        n_done++;
        if (done_c == 0) begin
          done_c = c;
          check({t, " req_done"}, req_done, 4'b1 << v.id);
          check({t, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
          check({t, " rsp_resp"}, rsp_resp, v.exp_resp);
          req_valid[v.id] = 1'b0;
        end
      end
      if (done_c != 0 && c == done_c + 2) break;
    end
    check({t, " latency"}, done_c, v.exp_lat);
    check({t, " done pulses"}, n_done, 1);
    check({t, " aw cycles"}, aw_c, v.wr ? v.exp_av : 0);
    check({t, " w cycles"}, w_c, v.exp_wv);
    check({t, " ar cycles"}, ar_c, v.wr ? 0 : v.exp_av);
    check({t, " ready cycles"}, rdy_c, v.exp_rdy);
    check({t, " idle after"}, busy, 0);
  endtask

  // Serves pending requesters; each drops req_valid when it sees req_done,
  // and 'rereq' raises its request again on the following cycle (once).
  task automatic serve(input int n, input int ord[8], input int rereq, input string t);
    int got = 0, last_c = -1;
    bit pend = 0, used = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge aclk);
      if (pend) begin req_valid[rereq] = 1'b1; pend = 0; end
      if (req_done != 0) begin
        check($sformatf("%s order %0d", t, got), grant_id, ord[got]);
        check($sformatf("%s onehot %0d", t, got), req_done, 4'b1 << ord[got]);
        if (last_c >= 0) check($sformatf("%s spacing %0d", t, got), c - last_c, 4);
        last_c = c;
        req_valid[grant_id] = 1'b0;
        if (int'(grant_id) == rereq && !used) begin pend = 1; used = 1; end
        got++;
      end
    end
    check({t, " served"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   ord[8];
  int   k;

  initial begin
    vecs[0] = '{wr:1, id:2, addr:32'h10, wdata:32'hDEADBEEF, strb:4'hF,
                aw_w:0, w_w:0, ar_w:0, rsp_w:0, s_rdata:32'hFFFFFFFF, s_resp:2'b00,
                exp_rdata:32'h0, exp_resp:2'b00, exp_lat:3, exp_av:1, exp_wv:1, exp_rdy:1};
    vecs[1] = '{wr:0, id:0, addr:32'h20, wdata:32'h0, strb:4'h0,
                aw_w:0, w_w:0, ar_w:0, rsp_w:3, s_rdata:32'h12345678, s_resp:2'b00,
                exp_rdata:32'h12345678, exp_resp:2'b00, exp_lat:6, exp_av:1, exp_wv:0, exp_rdy:4};
    vecs[2] = '{wr:1, id:1, addr:32'h104, wdata:32'hA5A50F0F, strb:4'hF,
                aw_w:5, w_w:0, ar_w:0, rsp_w:0, s_rdata:32'hFFFFFFFF, s_resp:2'b00,
                exp_rdata:32'h0, exp_resp:2'b00, exp_lat:8, exp_av:6, exp_wv:1, exp_rdy:1};
    vecs[3] = '{wr:1, id:3, addr:32'h3C, wdata:32'h00000001, strb:4'h1,
                aw_w:0, w_w:0, ar_w:0, rsp_w:0, s_rdata:32'hFFFFFFFF, s_resp:2'b10,
                exp_rdata:32'h0, exp_resp:2'b10, exp_lat:3, exp_av:1, exp_wv:1, exp_rdy:1};
    vecs[4] = '{wr:0, id:1, addr:32'h200, wdata:32'h0, strb:4'h0,
                aw_w:0, w_w:0, ar_w:2, rsp_w:0, s_rdata:32'hCAFEF00D, s_resp:2'b11,
                exp_rdata:32'hCAFEF00D, exp_resp:2'b11, exp_lat:5, exp_av:3, exp_wv:0, exp_rdy:1};
    vecs[5] = '{wr:1, id:0, addr:32'h8, wdata:32'h11223344, strb:4'h5,
                aw_w:2, w_w:4, ar_w:0, rsp_w:1, s_rdata:32'hFFFFFFFF, s_resp:2'b00,
                exp_rdata:32'h0, exp_resp:2'b00, exp_lat:8, exp_av:3, exp_wv:5, exp_rdy:2};

    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge aclk);
    check_reset("reset");
    aresetn = 1'b1;

    for (k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Reset while a read waits in RD_DATA.
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 20;
    @(negedge aclk);
    req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h44; req_valid[2] = 1'b1;
    begin
      int c;
      for (c = 0; c < 20 && !m_axil.rready; c++) @(negedge aclk);
      check("midrst reached RD_DATA", m_axil.rready, 1);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    req_valid = '0;
    @(negedge aclk);
    check_reset("midrst");
    r_wait = 0;
    aresetn = 1'b1;
    req_write = '0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    ord = '{1, 3, 0, 0, 0, 0, 0, 0};
    serve(2, ord, -1, "midrst");

    // Full contention held from reset; requester 1 asks again immediately.
    @(negedge aclk);
    aresetn = 1'b0;
    req_write = 4'b0101;
    req_valid = 4'b1111;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    ord = '{0, 1, 2, 3, 1, 0, 0, 0};
    serve(5, ord, 1, "contend");
    repeat (3) @(negedge aclk);
    check("contend idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
